// File: rtl/spcpu_instr_prefetch.sv
// rtl/spcpu_instr_prefetch.sv - sequential instruction prefetch FIFO for spcpu
// One request in flight at a time; redirect flushes the FIFO and discards a stale in-flight read.
module spcpu_instr_prefetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_addr,
  input  logic                    instr_ready,
  output logic                    instr_valid,
  output logic [15:0]             instr_word,
  output logic [ADDR_WIDTH-1:0]   instr_addr,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_ack,
  input  logic [15:0]             mem_rdata,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]           word_q [DEPTH];
  logic [15:0]           word_d [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  outstanding_q, outstanding_d;
  logic                  discard_q, discard_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [15:0]           instr_word_q, instr_word_d;
  logic [ADDR_WIDTH-1:0] instr_addr_q, instr_addr_d;
  logic                  ack, push, pop, busy;

  always_comb begin
    word_d        = word_q;
    addr_d        = addr_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_addr_d  = fetch_addr_q;
    mem_addr_d    = mem_addr_q;
    discard_d     = discard_q;
    ack           = outstanding_q && mem_ack;
    busy          = outstanding_q && !mem_ack;
    push          = 1'b0;
    pop           = 1'b0;

    if (redirect_valid) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      fetch_addr_d = redirect_addr & ~ADDR_WIDTH'(1);
      // A read still in flight belongs to the old stream; its data must be dropped on arrival.
      discard_d    = busy;
    end else begin
      pop  = instr_valid_q && instr_ready;
      push = ack && !discard_q;
      if (ack) discard_d = 1'b0;
      if (push) begin
        word_d[tail_q] = mem_rdata;
        addr_d[tail_q] = mem_addr_q;
        tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    outstanding_d = busy;
    if (!busy && count_d < CNT_W'(DEPTH)) begin
      outstanding_d = 1'b1;
      mem_addr_d    = fetch_addr_d;
      fetch_addr_d  = fetch_addr_d + ADDR_WIDTH'(2);
    end

    instr_valid_d = (count_d != '0);
    instr_word_d  = word_d[head_d];
    instr_addr_d  = addr_d[head_d];
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    addr_q <= addr_d;
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_addr_q  <= '0;
      mem_addr_q    <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_word_q  <= '0;
      instr_addr_q  <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_addr_q  <= fetch_addr_d;
      mem_addr_q    <= mem_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      instr_valid_q <= instr_valid_d;
      instr_word_q  <= instr_word_d;
      instr_addr_q  <= instr_addr_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr_word  = instr_word_q;
  assign instr_addr  = instr_addr_q;
  assign mem_req     = outstanding_q;
  assign mem_addr    = mem_addr_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_spcpu_instr_prefetch.sv
// tb/tb_spcpu_instr_prefetch.sv - directed and random checks of spcpu_instr_prefetch
// Reference model keeps the FIFO as a queue and the memory port as a single pending address.
module tb_spcpu_instr_prefetch;
  logic        clk = 1'b0;
  logic        reset, redirect_valid, instr_ready, mem_ack;
  logic [15:0] redirect_addr, mem_rdata;
  logic        instr_valid, mem_req;
  logic [15:0] instr_word, instr_addr, mem_addr;
  logic [2:0]  fifo_count;

  spcpu_instr_prefetch #(.ADDR_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr_word(instr_word),
    .instr_addr(instr_addr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] w; logic [15:0] a; } ent_t;
  ent_t        m_q[$];
  bit          m_pend, m_drop;
  logic [15:0] m_req_addr, m_fetch;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit   ack;
    ent_t e;
    ack = mem_ack && m_pend;
    if (reset) begin
      m_q.delete();
      m_pend = 0; m_drop = 0; m_req_addr = 16'h0; m_fetch = 16'h0;
      return;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_fetch = {redirect_addr[15:1], 1'b0};
      if (ack || !m_pend) begin m_pend = 0; m_drop = 0; end
      else m_drop = 1;
    end else begin
      if (instr_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (ack) begin
        if (m_drop) m_drop = 0;
        else begin e.w = mem_rdata; e.a = m_req_addr; m_q.push_back(e); end
        m_pend = 0;
      end
    end
    if (!m_pend && m_q.size() < 4) begin
      m_pend = 1; m_req_addr = m_fetch; m_fetch = m_fetch + 16'd2;
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("mem_req", 32'(mem_req), 32'(m_pend));
    if (m_pend) chk("mem_addr", 32'(mem_addr), 32'(m_req_addr));
    if (m_q.size() > 0) begin
      chk("instr_word", 32'(instr_word), 32'(m_q[0].w));
      chk("instr_addr", 32'(instr_addr), 32'(m_q[0].a));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_word"},  32'(instr_word),  32'h0);
    chk({tag, "_iaddr"}, 32'(instr_addr),  32'h0);
    chk({tag, "_req"},   32'(mem_req),     32'h0);
    chk({tag, "_maddr"}, 32'(mem_addr),    32'h0);
    chk({tag, "_count"}, 32'(fifo_count),  32'h0);
  endtask

  task automatic do_reset();
    reset = 1; redirect_valid = 0; redirect_addr = 0; instr_ready = 0; mem_ack = 0; mem_rdata = 0;
    step(); step();
    chk_reset_vals("rst");
    reset = 0;
  endtask

  initial begin
    #1;
    do_reset();

    // Streaming with data = addr, one pop per cycle.
    step();
    chk("first_req", 32'(mem_req), 32'h1);
    chk("first_addr", 32'(mem_addr), 32'h0);
    instr_ready = 1; mem_ack = 1;
    for (int i = 0; i < 12; i++) begin mem_rdata = mem_addr; step(); end

    // Fill to DEPTH, then one pop lets exactly one more fetch out.
    do_reset();
    mem_ack = 1;
    for (int i = 0; i < 8; i++) begin mem_rdata = 16'hA000 | mem_addr; step(); end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_req", 32'(mem_req), 32'h0);
    instr_ready = 1; step();
    instr_ready = 0;
    chk("after_pop_req", 32'(mem_req), 32'h1);
    chk("after_pop_addr", 32'(mem_addr), 32'h8);
    step(); step();

    // Redirect while 0x0006 is in flight; its data must never be visible.
    do_reset();
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin mem_rdata = 16'hB000 | mem_addr; step(); end
    mem_ack = 0; redirect_valid = 1; redirect_addr = 16'h0101; step();
    redirect_valid = 0;
    chk("held_addr", 32'(mem_addr), 32'h6);
    step(); step();
    mem_ack = 1; mem_rdata = 16'hDEAD; step();
    chk("discard_valid", 32'(instr_valid), 32'h0);
    chk("refetch_addr", 32'(mem_addr), 32'h0100);
    mem_ack = 0; mem_rdata = 16'h1234; step();
    mem_ack = 1; step();
    chk("redir_head", 32'(instr_addr), 32'h0100);
    mem_ack = 0; step();

    // Redirect coinciding with ack and pop.
    do_reset();
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin mem_rdata = 16'hC000 | mem_addr; step(); end
    redirect_valid = 1; redirect_addr = 16'h0200; instr_ready = 1; mem_rdata = 16'hBEEF; step();
    redirect_valid = 0;
    chk("same_cycle_count", 32'(fifo_count), 32'h0);
    chk("same_cycle_addr", 32'(mem_addr), 32'h0200);
    step(); step();

    // Address wrap at the top of memory.
    redirect_valid = 1; redirect_addr = 16'hFFFC; step();
    redirect_valid = 0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      mem_rdata = ~mem_addr; step();
      if (instr_valid) got.push_back(instr_addr);
    end
    chk("wrap_seen", 32'(got.size() >= 3), 32'h1);
    if (got.size() >= 3) begin
      chk("wrap0", 32'(got[0]), 32'hFFFC);
      chk("wrap1", 32'(got[1]), 32'hFFFE);
      chk("wrap2", 32'(got[2]), 32'h0000);
    end

    // Reset with a request outstanding and three entries buffered.
    do_reset();
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin mem_rdata = mem_addr; step(); end
    chk("pre_reset_count", 32'(fifo_count), 32'd3);
    mem_ack = 0; reset = 1; step();
    chk_reset_vals("midrst");
    reset = 0; mem_ack = 1; step();
    chk("stale_count", 32'(fifo_count), 32'h0);
    chk("restart_addr", 32'(mem_addr), 32'h0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset          = ($urandom_range(0, 149) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) redirect_addr = 16'hFFF8 | 16'($urandom_range(0, 7));
      instr_ready    = 1'($urandom);
      mem_ack        = ($urandom_range(0, 3) != 0);
      mem_rdata      = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
